// File: rtl/mem_pkg.sv
// mem_pkg: shared size encodings, access FSM state type and default timeout
package mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: little-endian lane select and sign/zero extension of load data
// Ports: rdata (raw word), addr (byte offset), size (mem_pkg size code),
//        uns (zero-extend when 1), data (aligned, extended result)
module mem_load_align import mem_pkg::*; (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);
  logic [31:0] sh;
  assign sh = rdata >> {addr, 3'b000};
  always_comb
    data = size == SZ_BYTE ? {{24{~uns & sh[7]}}, sh[7:0]} :
           size == SZ_HALF ? {{16{~uns & sh[15]}}, sh[15:0]} : rdata;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit over a req/ack data-memory bus
// Ports: EX/MEM controls and operands in; dmem_* bus; stall to freeze the
//        front of the pipeline; MEM/WB bundle out; access_err/err_addr report
//        misaligned, illegal and timed-out accesses (rst is async active-low).
module mem_access_unit import mem_pkg::*; #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [1:0]  control_wb_in,
  input  logic [4:0]  write_reg_in,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  output logic        stall,
  output logic [1:0]  control_wb_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_reg_out,
  output logic        access_err,
  output logic [31:0] err_addr
);
  state_t state;
  logic [7:0] cnt;
  logic [31:0] rd_q, ld_data;
  logic to_q, access, bad, start, expire;
  logic [1:0] a;
  assign a = alu_result_in[1:0];
  assign access = mem_read | mem_write;
  assign bad = (mem_read & mem_write) | (mem_size == 2'b11) |
               (mem_size == SZ_HALF && a[0]) | (mem_size == SZ_WORD && a != 2'b00);
  // IDLE-path decisions are gated by rst so outputs drop the moment reset asserts
  assign start = rst && state == IDLE && access && !bad;
  // ack in the expiry cycle takes priority over the timeout
  assign expire = state == BUSY && !dmem_ack && cnt == 8'(TIMEOUT_CYCLES - 1);
  assign dmem_req = state == BUSY;
  assign dmem_we = dmem_req & mem_write;
  assign dmem_addr = {alu_result_in[31:2], 2'b00};
  assign stall = start | dmem_req;
  assign access_err = (rst && state == IDLE && access && bad) | expire;
  assign alu_result_out = alu_result_in;
  assign write_reg_out = write_reg_in;
  assign read_data_out = state == DONE ? rd_q : 32'd0;
  mem_load_align u_align (
    .rdata(dmem_rdata),
    .addr (a),
    .size (mem_size),
    .uns  (mem_unsigned),
    .data (ld_data)
  );
  always_comb begin
    dmem_be = mem_size == SZ_BYTE ? 4'b0001 << a :
              mem_size == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    dmem_wdata = !mem_write ? 32'd0 :
                 mem_size == SZ_BYTE ? {4{store_data_in[7:0]}} :
                 mem_size == SZ_HALF ? {2{store_data_in[15:0]}} : store_data_in;
    // stall and error cycles present a bubble so MEM/WB never writes twice
    control_wb_out = state == DONE ? (to_q ? 2'b00 : control_wb_in) :
                     (rst && state == IDLE && !access) ? control_wb_in : 2'b00;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= 8'd0;
      rd_q <= 32'd0;
      to_q <= 1'b0;
      err_addr <= 32'd0;
    end else begin
      if (access_err) err_addr <= alu_result_in;
      case (state)
        IDLE: if (start) begin
          state <= BUSY;
          cnt <= 8'd0;
          to_q <= 1'b0;
        end
        BUSY: begin
          cnt <= cnt + 8'd1;
          if (dmem_ack) begin
            state <= DONE;
            rd_q <= mem_read ? ld_data : 32'd0;
          end else if (expire) begin
            state <= DONE;
            to_q <= 1'b1;
            rd_q <= 32'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store checks against a behavioural model
module tb_mem_access_unit;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic mem_read = 0, mem_write = 0, mem_unsigned = 0, dmem_ack = 0;
  logic [1:0] mem_size = 0, control_wb_in = 0;
  logic [31:0] alu_result_in = 0, store_data_in = 0, dmem_rdata = 0;
  logic [4:0] write_reg_in = 0;
  logic dmem_req, dmem_we, stall, access_err;
  logic [31:0] dmem_addr, dmem_wdata, read_data_out, alu_result_out, err_addr;
  logic [3:0] dmem_be;
  logic [1:0] control_wb_out;
  logic [4:0] write_reg_out;
  int vecs = 0, errs = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .alu_result_in(alu_result_in),
    .store_data_in(store_data_in), .control_wb_in(control_wb_in), .write_reg_in(write_reg_in),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .stall(stall),
    .control_wb_out(control_wb_out), .read_data_out(read_data_out),
    .alu_result_out(alu_result_out), .write_reg_out(write_reg_out),
    .access_err(access_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] rdat, input logic [1:0] sz,
                                           input logic [1:0] off, input logic un);
    longint v, m;
    m = longint'(1) << (8 * (1 << sz));
    v = longint'(rdat >> (8 * off)) % m;
    if (!un && v >= m / 2) v -= m;
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] off);
    int b;
    b = sz == 0 ? 1 << off : sz == 1 ? 3 << off : 15;
    return b[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] sd);
    return sz == 0 ? (sd & 32'hFF) * 32'h01010101 :
           sz == 1 ? (sd & 32'hFFFF) * 32'h00010001 : sd;
  endfunction

  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic un,
                    input logic [31:0] ad, input logic [31:0] sd, input logic [31:0] rdat,
                    input logic [1:0] wb, input int dly);
    logic acc, bd, got;
    logic [31:0] expd;
    logic [4:0] wr_reg;
    acc = rd | wr;
    bd = acc && ((rd && wr) || sz == 2'b11 || (ad % (32'd1 << sz)) != 0);
    wr_reg = 5'($urandom);
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = un;
    alu_result_in = ad; store_data_in = sd; control_wb_in = wb; write_reg_in = wr_reg;
    dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    #1;
    chk("alu_pass", alu_result_out, ad);
    chk("reg_pass", {27'd0, write_reg_out}, {27'd0, wr_reg});
    chk("idle_req", dmem_req, 0);
    if (!acc) begin
      chk("nop_stall", stall, 0);
      chk("nop_cwb", control_wb_out, wb);
      chk("nop_rdata", read_data_out, 0);
      chk("nop_err", access_err, 0);
      return;
    end
    if (bd) begin
      chk("bad_stall", stall, 0);
      chk("bad_err", access_err, 1);
      chk("bad_cwb", control_wb_out, 0);
      @(negedge clk);
      mem_read = 0; mem_write = 0;
      #1;
      chk("bad_eaddr", err_addr, ad);
      chk("bad_err_pulse", access_err, 0);
      return;
    end
    chk("start_stall", stall, 1);
    chk("start_err", access_err, 0);
    got = 0; expd = 0;
    for (int k = 0; k < TO && !got; k++) begin
      @(negedge clk);
      dmem_ack = k == dly;
      dmem_rdata = k == dly ? rdat : $urandom;
      #1;
      chk("busy_req", dmem_req, 1);
      chk("busy_stall", stall, 1);
      chk("busy_we", dmem_we, wr);
      chk("busy_addr", dmem_addr, ad & ~32'd3);
      chk("busy_be", dmem_be, exp_be(sz, ad[1:0]));
      chk("busy_wdata", dmem_wdata, wr ? exp_wdata(sz, sd) : 0);
      chk("busy_err", access_err, k == TO - 1 && k != dly);
      if (k == dly) begin
        got = 1;
        expd = rd ? exp_load(rdat, sz, ad[1:0], un) : 0;
      end
    end
    @(negedge clk);
    dmem_ack = 0;
    #1;
    chk("done_req", dmem_req, 0);
    chk("done_stall", stall, 0);
    chk("done_err", access_err, 0);
    chk("done_rdata", read_data_out, expd);
    chk("done_cwb", control_wb_out, got ? wb : 2'b00);
    if (!got) chk("to_eaddr", err_addr, ad);
  endtask

  initial begin
    control_wb_in = 2'b11;
    #12;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_err", access_err, 0);
    chk("rst_eaddr", err_addr, 0);
    chk("rst_rdata", read_data_out, 0);
    chk("rst_cwb", control_wb_out, 0);
    @(negedge clk);
    rst = 1;
    op(1, 0, 2'b00, 0, 32'h1001, 0, 32'h00008000, 2'b10, 0);
    op(0, 1, 2'b01, 0, 32'h2002, 32'h1234ABCD, 0, 2'b01, 1);
    op(1, 0, 2'b10, 1, 32'h3000, 0, 32'hCAFEF00D, 2'b11, 3);
    op(1, 0, 2'b10, 0, 32'h3002, 0, 0, 2'b11, 0);
    op(1, 0, 2'b10, 0, 32'h5004, 0, 0, 2'b11, 10);
    op(1, 0, 2'b01, 0, 32'h6006, 0, 32'h8001_0000, 2'b11, TO - 1);
    op(0, 0, 2'b00, 0, 32'h7777, 0, 0, 2'b01, 0);
    @(negedge clk);
    mem_read = 1; mem_write = 0; mem_size = 2'b10; alu_result_in = 32'h4000; control_wb_in = 2'b11;
    @(negedge clk);
    #1;
    chk("mid_req", dmem_req, 1);
    @(negedge clk);
    #2 rst = 0;
    #1;
    chk("mrst_req", dmem_req, 0);
    chk("mrst_stall", stall, 0);
    chk("mrst_err", access_err, 0);
    chk("mrst_eaddr", err_addr, 0);
    chk("mrst_rdata", read_data_out, 0);
    chk("mrst_cwb", control_wb_out, 0);
    @(negedge clk);
    mem_read = 0;
    rst = 1;
    op(1, 0, 2'b00, 1, 32'h40FF, 0, 32'h9ABC_DEF0, 2'b10, 2);
    for (int i = 0; i < 250; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      op(kind inside {1, 2, 3, 4, 9}, kind inside {5, 6, 7, 8, 9}, 2'($urandom), 1'($urandom),
         $urandom, $urandom, $urandom, 2'($urandom), $urandom_range(0, TO + 1));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit of the 5-stage pipeline, sitting between the EX/MEM register and the MEM/WB register. It runs loads and stores over a req/ack data-memory bus, freezes the pipeline with `stall` while an access is outstanding, and forms byte enables and store data. It also aligns and extends load data and presents the write-back bundle to MEM/WB. It detects misaligned or illegal accesses and bus timeouts, and converts the affected instruction into a write-back bubble.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles in BUSY without ack before the access is abandoned (range 1..255).
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `mem_read`, `mem_write` input 1 each: access type from EX/MEM.
- `mem_size` input 2: 00 byte, 01 half, 10 word, 11 illegal.
- `mem_unsigned` input 1: zero-extend loads when 1, sign-extend when 0.
- `alu_result_in` input 32: effective address for memory ops, pass-through value otherwise.
- `store_data_in` input 32: rt value for stores.
- `control_wb_in` input 2: write-back controls.
- `write_reg_in` input 5: destination register.
- `dmem_rdata` input 32: memory read data.
- `dmem_ack` input 1: completion pulse, valid only while `dmem_req`=1.
- `dmem_req` output 1: request.
- `dmem_we` output 1: write enable.
- `dmem_addr` output 32: word-aligned address, `{alu_result_in[31:2],2'b00}`.
- `dmem_be` output 4: byte enables.
- `dmem_wdata` output 32: lane-replicated store data.
- `stall` output 1: holds PC, IF/ID, ID/EX and EX/MEM.
- `control_wb_out`, `read_data_out`, `alu_result_out`, `write_reg_out` output 2/32/32/5: feed MEM/WB.
- `access_err` output 1: one-cycle pulse on error.
- `err_addr` output 32: address of the last error, held until the next error.

## Operation
- **Access conditions.** `access` = `mem_read` OR `mem_write`. `bad` = any of:
  - both `mem_read` and `mem_write` set;
  - `mem_size`=11;
  - half access with `addr[0]`=1;
  - word access with `addr[1:0]`≠00.
- **FSM states:** IDLE, BUSY, DONE (state type in package).
- **IDLE:**
  - No access: pass-through. `control_wb_out`=`control_wb_in`, `read_data_out`=0, `stall`=0.
  - `access` and `bad`: no bus cycle, `stall`=0, `control_wb_out`=00, `access_err` pulses, `err_addr` latched.
  - `access` and not `bad`: `stall`=1, go to BUSY, clear the timeout counter.
- **BUSY:**
  - `dmem_req`=1 and `stall`=1; bus outputs are driven from the held EX/MEM inputs.
  - On `dmem_ack`: latch the formatted load data (0 for stores) and go to DONE.
  - If the counter reaches `TIMEOUT_CYCLES`: set the error flag, pulse `access_err`, latch `err_addr`, go to DONE.
- **DONE:** `stall`=0. `read_data_out` comes from the latch. `control_wb_out`=`control_wb_in`, or 00 if the timeout flag is set. Return to IDLE.
- **Store formatting:**
  - Byte: `be` = 0001 shifted left by `addr[1:0]`; `wdata` = `{4{sd[7:0]}}`.
  - Half: `be` = 1100 if `addr[1]`=1, else 0011; `wdata` = `{2{sd[15:0]}}`.
  - Word: `be` = 1111; `wdata` = `sd`.
- **Load formatting:** little-endian lane select by `addr[1:0]`, then sign- or zero-extend to 32 bits per `mem_unsigned`. For loads `dmem_be` is driven as for stores and `dmem_wdata`=0.
- **Pass-through:** `alu_result_out` and `write_reg_out` always equal their inputs.
- **Reset:** async reset at any time, including mid-BUSY, forces:
  - state IDLE, counter and latches 0;
  - `dmem_req`=0, `stall`=0, `access_err`=0, `err_addr`=0;
  - `read_data_out`=0, `control_wb_out`=00.

## Timing
- **Latency:** a memory op with ack arriving N cycles after entering BUSY (N≥0; ack in the first BUSY cycle is N=0) stalls for N+2 cycles (IDLE cycle + BUSY cycles). DONE is the capture cycle for MEM/WB.
- Non-memory and `bad` ops: zero added latency.
- `dmem_req` is a pure function of state, so it deasserts the cycle after ack.
- Ack while `dmem_req`=0 is ignored.
- Ack in the same cycle the counter expires: ack wins, no error.
- `access_err` is high exactly one cycle per error.
- Back-to-back memory ops: DONE → IDLE → BUSY, so at least one stall-free cycle separates consecutive accesses.

## Structure
- Shared package `mem_pkg`:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - FSM state typedef;
  - `TIMEOUT_CYCLES` default constant.
- Sub-module `mem_load_align`: combinational lane select plus extension (inputs rdata, `addr[1:0]`, size, unsigned). It is reused by any future cache path.

## Test plan
- Signed byte load at 0x1001, rdata=0x00008000 → after ack, `read_data_out`=0xFFFFFF80, `control_wb_out`=`control_wb_in`, `dmem_be`=0010.
- Store half at 0x2002, rt=0x1234ABCD → `dmem_be`=1100, `dmem_wdata`=0xABCDABCD, `dmem_we`=1.
- Word load with ack delayed N=3 → `stall` high for exactly 5 cycles, `dmem_req` high for 4.
- Word load at 0x3002 → no `dmem_req`, `stall`=0, `access_err` one-cycle pulse, `err_addr`=0x3002, `control_wb_out`=00.
- `TIMEOUT_CYCLES`=4, no ack → `access_err` after 4 BUSY cycles, DONE has `control_wb_out`=00; repeat with ack on the expiry cycle → no error.
- Reset asserted mid-BUSY → `dmem_req`/`stall` drop immediately, all outputs at reset values, next op proceeds normally.
